// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter and its frame streamer.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_EMIT,
      ST_DONE
   } st_e;

   typedef enum logic [1:0] {
      PL_R,
      PL_G,
      PL_B
   } plane_e;

   localparam int LANES  = 4;
   localparam int LANE_W = 32;
   localparam int WORD_W = LANES * LANE_W;

   function automatic plane_e plane_of(input int unsigned word, input int unsigned plane_words);
      if (word < plane_words)
         plane_of = PL_R;
      else if (word < 2 * plane_words)
         plane_of = PL_G;
      else
         plane_of = PL_B;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the pipeline, memory, streamer-control and GPIO signals of the arbiter.
interface mem_port_arbiter_if;
   import mem_arb_pkg::*;

   logic              pipe_rmem_i;
   logic              pipe_wmem_i;
   logic              pipe_vf_i;
   logic [31:0]       pipe_addr_i;
   logic [WORD_W-1:0] pipe_wdata_i;
   logic              mem_rmem_o;
   logic              mem_wmem_o;
   logic              mem_vf_o;
   logic [31:0]       mem_addr_o;
   logic [WORD_W-1:0] mem_wdata_o;
   logic [WORD_W-1:0] mem_rdata_i;
   logic              stall_o;
   logic              start_i;
   logic [31:0]       base_addr_i;
   logic              busy_o;
   logic              done_o;
   logic [LANE_W-1:0] gpio_o;
   logic              gpio_en_o;
   logic              gpio_en_r_o;
   logic              gpio_en_g_o;
   logic              gpio_en_b_o;

   modport slave (
      input  pipe_rmem_i, pipe_wmem_i, pipe_vf_i, pipe_addr_i, pipe_wdata_i,
      input  mem_rdata_i, start_i, base_addr_i,
      output mem_rmem_o, mem_wmem_o, mem_vf_o, mem_addr_o, mem_wdata_o,
      output stall_o, busy_o, done_o, gpio_o, gpio_en_o, gpio_en_r_o, gpio_en_g_o, gpio_en_b_o
   );

   modport master (
      output pipe_rmem_i, pipe_wmem_i, pipe_vf_i, pipe_addr_i, pipe_wdata_i,
      output mem_rdata_i, start_i, base_addr_i,
      input  mem_rmem_o, mem_wmem_o, mem_vf_o, mem_addr_o, mem_wdata_o,
      input  stall_o, busy_o, done_o, gpio_o, gpio_en_o, gpio_en_r_o, gpio_en_g_o, gpio_en_b_o
   );

endinterface

// File: rtl/gpio_streamer.sv
// Frame streamer: fetches one 128-bit word per FETCH grant and emits it as 4 GPIO beats.
// Waits in FETCH indefinitely for grant_i; all outputs decode straight from registers.
module gpio_streamer
   import mem_arb_pkg::*;
#(
   parameter int unsigned PLANE_WORDS = 16,
   parameter int unsigned ADDR_STEP   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [31:0]       base_addr_i,
   input  logic              grant_i,
   input  logic [WORD_W-1:0] rdata_i,
   output logic              req_o,
   output logic [31:0]       addr_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [LANE_W-1:0] gpio_o,
   output logic              gpio_en_o,
   output logic              gpio_en_r_o,
   output logic              gpio_en_g_o,
   output logic              gpio_en_b_o
);

   localparam int WB = $clog2(3 * PLANE_WORDS + 1);
   localparam logic [WB-1:0] LAST_WORD = WB'(3 * PLANE_WORDS - 1);
   localparam logic [1:0]    LAST_LANE = 2'(LANES - 1);

   st_e               state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [WB-1:0]     word_q, word_d;
   logic [1:0]        lane_q, lane_d;
   logic [WORD_W-1:0] buf_q, buf_d;
   logic              emit;
   plane_e            plane;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         word_q  <= '0;
         lane_q  <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         lane_q  <= lane_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      word_d  = word_q;
      lane_d  = lane_q;
      buf_d   = buf_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               addr_d  = base_addr_i;
               word_d  = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (grant_i)
               state_d = ST_WAIT;
         end
         ST_WAIT: begin
            buf_d   = rdata_i;
            lane_d  = '0;
            state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (lane_q == LAST_LANE) begin
               if (word_q == LAST_WORD) begin
                  state_d = ST_DONE;
               end else begin
                  word_d  = word_q + 1'b1;
                  addr_d  = addr_q + 32'(ADDR_STEP);
                  state_d = ST_FETCH;
               end
            end else begin
               lane_d = lane_q + 1'b1;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign emit  = (state_q == ST_EMIT);
   assign plane = plane_of(32'(word_q), PLANE_WORDS);

   assign req_o       = (state_q == ST_FETCH);
   assign addr_o      = addr_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = (state_q == ST_DONE);
   assign gpio_en_o   = emit;
   assign gpio_o      = emit ? buf_q[LANE_W*lane_q +: LANE_W] : '0;
   assign gpio_en_r_o = emit && (plane == PL_R);
   assign gpio_en_g_o = emit && (plane == PL_G);
   assign gpio_en_b_o = emit && (plane == PL_B);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between the MEM stage and the frame streamer, zero added latency.
// Pipeline has priority; a streamer starved for STARVE_MAX cycles takes the port and stalls the pipe.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned PLANE_WORDS = 16,
   parameter int unsigned STARVE_MAX  = 8,
   parameter int unsigned ADDR_STEP   = 16
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic          pipe_req;
   logic          st_req;
   logic          st_grant;
   logic          force_c;
   logic [31:0]   st_addr;
   logic [SW-1:0] starve_cnt_q, starve_cnt_d;

   gpio_streamer #(
      .PLANE_WORDS(PLANE_WORDS),
      .ADDR_STEP  (ADDR_STEP)
   ) u_streamer (
      .clk        (clk),
      .rst        (rst),
      .start_i    (bus.start_i),
      .base_addr_i(bus.base_addr_i),
      .grant_i    (st_grant),
      .rdata_i    (bus.mem_rdata_i),
      .req_o      (st_req),
      .addr_o     (st_addr),
      .busy_o     (bus.busy_o),
      .done_o     (bus.done_o),
      .gpio_o     (bus.gpio_o),
      .gpio_en_o  (bus.gpio_en_o),
      .gpio_en_r_o(bus.gpio_en_r_o),
      .gpio_en_g_o(bus.gpio_en_g_o),
      .gpio_en_b_o(bus.gpio_en_b_o)
   );

   assign pipe_req    = bus.pipe_rmem_i | bus.pipe_wmem_i;
   assign force_c     = st_req && (starve_cnt_q == STARVE_LIM);
   assign st_grant    = st_req && (force_c || !pipe_req);
   assign bus.stall_o = force_c;

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (st_grant)
         starve_cnt_d = '0;
      else if (st_req && (starve_cnt_q != STARVE_LIM))
         starve_cnt_d = starve_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve_cnt_q <= '0;
      else
         starve_cnt_q <= starve_cnt_d;
   end

   // Address and data are zeroed when nobody owns the port so the bus is quiet.
   always_comb begin
      bus.mem_rmem_o  = 1'b0;
      bus.mem_wmem_o  = 1'b0;
      bus.mem_vf_o    = 1'b0;
      bus.mem_addr_o  = '0;
      bus.mem_wdata_o = '0;
      if (st_grant) begin
         bus.mem_rmem_o = 1'b1;
         bus.mem_vf_o   = 1'b1;
         bus.mem_addr_o = st_addr;
      end else if (pipe_req) begin
         bus.mem_rmem_o  = bus.pipe_rmem_i;
         bus.mem_wmem_o  = bus.pipe_wmem_i;
         bus.mem_vf_o    = bus.pipe_vf_i;
         bus.mem_addr_o  = bus.pipe_addr_i;
         bus.mem_wdata_o = bus.pipe_wdata_i;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a per-cycle reference model (PLANE_WORDS=1).
module tb_mem_port_arbiter;

   localparam int PW     = 1;
   localparam int STARVE = 8;

   logic clk;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .PLANE_WORDS(PW),
      .STARVE_MAX (STARVE),
      .ADDR_STEP  (16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [127:0] img(input logic [31:0] a);
      logic [127:0] w;
      for (int i = 0; i < 4; i++)
         w[32*i +: 32] = 32'hC0DE_0000 | a | 32'(i);
      return w;
   endfunction

   // Memory with one-cycle read latency.
   logic [127:0] mem [bit [31:0]];
   always @(posedge clk) begin
      if (bus.mem_wmem_o)
         mem[bus.mem_addr_o] = bus.mem_wdata_o;
      if (bus.mem_rmem_o)
         bus.mem_rdata_i <= mem.exists(bus.mem_addr_o) ? mem[bus.mem_addr_o] : 128'h0;
   end

   // Reference model: frame progress as (word, position within word).
   // pos 0 = waiting for the port, 1 = data returning, 2..5 = lanes 0..3, 6 = done.
   bit          m_active = 0;
   logic [31:0] m_base   = '0;
   int          m_word   = 0;
   int          m_pos    = 0;
   int          m_starve = 0;
   bit          m_sgrant = 0;
   bit          c_preq, c_sreq, c_frc, c_emit;
   logic [31:0] c_exp_gpio;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active = 0;
         m_starve = 0;
         m_pos    = 0;
         m_word   = 0;
      end else if (!m_active) begin
         if (bus.start_i) begin
            m_active = 1;
            m_base   = bus.base_addr_i;
            m_word   = 0;
            m_pos    = 0;
         end
      end else begin
         case (m_pos)
            0: begin
               if (m_sgrant) begin
                  m_pos    = 1;
                  m_starve = 0;
               end else if (m_starve < STARVE) begin
                  m_starve++;
               end
            end
            5: begin
               if (m_word == 3*PW - 1) m_pos = 6;
               else begin
                  m_word++;
                  m_pos = 0;
               end
            end
            6: m_active = 0;
            default: m_pos++;
         endcase
      end
   end

   always @(negedge clk) begin
      c_preq   = bus.pipe_rmem_i | bus.pipe_wmem_i;
      c_sreq   = m_active && (m_pos == 0);
      c_frc    = c_sreq && (m_starve == STARVE);
      m_sgrant = c_sreq && (c_frc || !c_preq);
      chk("m_stall", bus.stall_o, c_frc);
      if (m_sgrant) begin
         chk("m_rmem", bus.mem_rmem_o, 1'b1);
         chk("m_wmem", bus.mem_wmem_o, 1'b0);
         chk("m_vf", bus.mem_vf_o, 1'b1);
         chk("m_addr", bus.mem_addr_o, m_base + 32'(m_word * 16));
         chk("m_wdata", bus.mem_wdata_o, 128'h0);
      end else if (c_preq) begin
         chk("m_rmem", bus.mem_rmem_o, bus.pipe_rmem_i);
         chk("m_wmem", bus.mem_wmem_o, bus.pipe_wmem_i);
         chk("m_vf", bus.mem_vf_o, bus.pipe_vf_i);
         chk("m_addr", bus.mem_addr_o, bus.pipe_addr_i);
         chk("m_wdata", bus.mem_wdata_o, bus.pipe_wdata_i);
      end else begin
         chk("m_rmem", bus.mem_rmem_o, 1'b0);
         chk("m_wmem", bus.mem_wmem_o, 1'b0);
         chk("m_vf", bus.mem_vf_o, 1'b0);
      end
      c_emit     = m_active && (m_pos >= 2) && (m_pos <= 5);
      c_exp_gpio = c_emit ? 32'(img(m_base + 32'(m_word * 16)) >> (32 * (m_pos - 2))) : 32'h0;
      chk("m_busy", bus.busy_o, m_active);
      chk("m_done", bus.done_o, m_active && (m_pos == 6));
      chk("m_gpio_en", bus.gpio_en_o, c_emit);
      chk("m_en_r", bus.gpio_en_r_o, c_emit && (m_word < PW));
      chk("m_en_g", bus.gpio_en_g_o, c_emit && (m_word >= PW) && (m_word < 2*PW));
      chk("m_en_b", bus.gpio_en_b_o, c_emit && (m_word >= 2*PW));
      chk("m_gpio", bus.gpio_o, c_exp_gpio);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [31:0] base);
      bus.base_addr_i = base;
      bus.start_i     = 1'b1;
      step();
      bus.start_i     = 1'b0;
   endtask

   int n_done;
   int n_stall;

   initial begin
      rst              = 1'b1;
      bus.pipe_rmem_i  = 1'b0;
      bus.pipe_wmem_i  = 1'b0;
      bus.pipe_vf_i    = 1'b0;
      bus.pipe_addr_i  = '0;
      bus.pipe_wdata_i = '0;
      bus.mem_rdata_i  = '0;
      bus.start_i      = 1'b0;
      bus.base_addr_i  = '0;
      for (int a = 'h100; a <= 'h130; a += 'h10)
         mem[32'(a)] = img(32'(a));

      step();
      @(negedge clk);
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_done", bus.done_o, 1'b0);
      chk("rst_gpio_en", bus.gpio_en_o, 1'b0);
      chk("rst_stall", bus.stall_o, 1'b0);
      step();
      rst = 1'b0;
      step();

      // Pipeline alone: read then write pass straight through.
      bus.pipe_rmem_i = 1'b1;
      bus.pipe_addr_i = 32'h40;
      @(negedge clk);
      chk("pipe_rd_rmem", bus.mem_rmem_o, 1'b1);
      chk("pipe_rd_addr", bus.mem_addr_o, 32'h40);
      chk("pipe_rd_stall", bus.stall_o, 1'b0);
      step();
      bus.pipe_rmem_i  = 1'b0;
      bus.pipe_wmem_i  = 1'b1;
      bus.pipe_addr_i  = 32'h200;
      bus.pipe_wdata_i = {16{8'hA5}};
      @(negedge clk);
      chk("pipe_wr_wmem", bus.mem_wmem_o, 1'b1);
      chk("pipe_wr_data", bus.mem_wdata_o, {16{8'hA5}});
      step();
      bus.pipe_wmem_i = 1'b0;
      step();

      // Uncontended frame from 0x100.
      start_frame(32'h100);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         case (c)
            1:  begin chk("f_rd1", bus.mem_rmem_o, 1'b1); chk("f_rd1_addr", bus.mem_addr_o, 32'h100); end
            2:  chk("f_wait_quiet", bus.gpio_en_o, 1'b0);
            3:  begin chk("f_r_en", bus.gpio_en_r_o, 1'b1); chk("f_lane0", bus.gpio_o, 32'hC0DE0100); end
            6:  begin chk("f_r_en6", bus.gpio_en_r_o, 1'b1); chk("f_lane3", bus.gpio_o, 32'hC0DE0103); end
            7:  chk("f_rd2_addr", bus.mem_addr_o, 32'h110);
            9:  begin chk("f_g_en", bus.gpio_en_g_o, 1'b1); chk("f_g_lane0", bus.gpio_o, 32'hC0DE0110); end
            13: chk("f_rd3_addr", bus.mem_addr_o, 32'h120);
            15: chk("f_b_en", bus.gpio_en_b_o, 1'b1);
            18: begin chk("f_b_en18", bus.gpio_en_b_o, 1'b1); chk("f_b_lane3", bus.gpio_o, 32'hC0DE0123); end
            19: chk("f_done", bus.done_o, 1'b1);
            20: chk("f_idle_busy", bus.busy_o, 1'b0);
            default: ;
         endcase
         step();
      end

      // start_i while busy with another base is ignored.
      n_done = 0;
      start_frame(32'h100);
      for (int c = 1; c <= 22; c++) begin
         bus.start_i     = (c == 5);
         bus.base_addr_i = (c == 5) ? 32'h300 : 32'h100;
         @(negedge clk);
         if (bus.done_o) n_done++;
         if (c == 13) chk("ign_rd3_addr", bus.mem_addr_o, 32'h120);
         step();
      end
      bus.start_i = 1'b0;
      chk("ign_done_cnt", 32'(n_done), 32'd1);

      // Pipeline write collides with FETCH; streamer reads next idle cycle.
      start_frame(32'h100);
      for (int c = 1; c <= 21; c++) begin
         bus.pipe_wmem_i  = (c == 1);
         bus.pipe_addr_i  = 32'h200;
         bus.pipe_wdata_i = {4{32'h1234_5678}};
         @(negedge clk);
         if (c == 1) begin
            chk("col_wmem", bus.mem_wmem_o, 1'b1);
            chk("col_rmem", bus.mem_rmem_o, 1'b0);
            chk("col_stall", bus.stall_o, 1'b0);
            chk("col_addr", bus.mem_addr_o, 32'h200);
         end
         if (c == 2) begin
            chk("col_rd_rmem", bus.mem_rmem_o, 1'b1);
            chk("col_rd_addr", bus.mem_addr_o, 32'h100);
         end
         if (c == 20) chk("col_done", bus.done_o, 1'b1);
         step();
      end
      bus.pipe_wmem_i = 1'b0;

      // Pipeline requesting every cycle: forced grant after 8 denials per word.
      bus.pipe_rmem_i = 1'b1;
      bus.pipe_addr_i = 32'h40;
      n_stall = 0;
      start_frame(32'h100);
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (bus.stall_o) n_stall++;
         case (c)
            1:  begin chk("st_c1_addr", bus.mem_addr_o, 32'h40); chk("st_c1_stall", bus.stall_o, 1'b0); end
            8:  chk("st_c8_stall", bus.stall_o, 1'b0);
            9:  begin chk("st_c9_stall", bus.stall_o, 1'b1); chk("st_c9_addr", bus.mem_addr_o, 32'h100); end
            10: chk("st_c10_stall", bus.stall_o, 1'b0);
            22: chk("st_c22_stall", bus.stall_o, 1'b0);
            23: begin chk("st_c23_stall", bus.stall_o, 1'b1); chk("st_c23_addr", bus.mem_addr_o, 32'h110); end
            37: chk("st_c37_addr", bus.mem_addr_o, 32'h120);
            43: chk("st_done", bus.done_o, 1'b1);
            default: ;
         endcase
         step();
      end
      chk("st_stall_cnt", 32'(n_stall), 32'd3);
      bus.pipe_rmem_i = 1'b0;
      step();

      // Reset in the middle of an EMIT beat, then restart at a new base.
      start_frame(32'h100);
      step();
      step();
      step();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_gpio_en", bus.gpio_en_o, 1'b0);
      chk("mid_rst_en_r", bus.gpio_en_r_o, 1'b0);
      chk("mid_rst_gpio", bus.gpio_o, 32'h0);
      chk("mid_rst_busy", bus.busy_o, 1'b0);
      step();
      rst = 1'b0;
      n_done = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (bus.done_o) n_done++;
         step();
      end
      chk("mid_rst_no_done", 32'(n_done), 32'd0);
      start_frame(32'h110);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1)  chk("re_rd1_addr", bus.mem_addr_o, 32'h110);
         if (c == 3)  chk("re_lane0", bus.gpio_o, 32'hC0DE0110);
         if (c == 19) chk("re_done", bus.done_o, 1'b1);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
